// File: rtl/conv_cfg_pkg.sv
// Shared constants and types for the convolution tile scheduler.
// Holds the pass geometry, field widths, state encoding and the latched layer config record.
package conv_cfg_pkg;

    localparam int unsigned OX_PER_PASS = 32;
    localparam int unsigned OY_PER_PASS = 3;
    localparam int unsigned OF_PER_PASS = 64;
    localparam int unsigned PIPE_LAT    = 6;
    localparam int unsigned CNT_W       = 32;

    localparam int unsigned DIM_W = 16;
    localparam int unsigned KSP_W = 4;
    localparam int unsigned NKK_W = 32;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_KICK = 3'd2;
    localparam logic [2:0] ST_RUN  = 3'd3;
    localparam logic [2:0] ST_HOLD = 3'd4;
    localparam logic [2:0] ST_FIN  = 3'd5;

    typedef struct packed {
        logic [DIM_W-1:0] of;
        logic [DIM_W-1:0] ox;
        logic [DIM_W-1:0] oy;
        logic [NKK_W-1:0] nif_k_k;
        logic             mode;
    } layer_cfg_t;

endpackage

// File: rtl/conv_tile_scheduler_if.sv
// Control, datapath-sequencing and result-handshake signals of the tile scheduler.
// master = layer controller / write-back side, slave = the scheduler.
interface conv_tile_scheduler_if;
    import conv_cfg_pkg::*;

    logic             start;
    logic [KSP_W-1:0] cfg_k;
    logic [KSP_W-1:0] cfg_s;
    logic [KSP_W-1:0] cfg_p;
    logic [DIM_W-1:0] cfg_of;
    logic [DIM_W-1:0] cfg_ox;
    logic [DIM_W-1:0] cfg_oy;
    logic [DIM_W-1:0] cfg_ix;
    logic [DIM_W-1:0] cfg_iy;
    logic [DIM_W-1:0] cfg_nif;
    logic [DIM_W-1:0] cfg_nif_in_2pow;
    logic [DIM_W-1:0] cfg_ix_in_2pow;
    logic [NKK_W-1:0] cfg_nif_k_k;
    logic             cfg_mode;

    logic             dp_reset;
    logic             dp_en;
    logic             dp_mode;
    logic [DIM_W-1:0] tile_ox;
    logic [DIM_W-1:0] tile_oy;
    logic [DIM_W-1:0] tile_of;
    logic             res_valid;
    logic             res_ready;
    logic             busy;
    logic             done;
    logic             cfg_err;

    modport master (
        output start, cfg_k, cfg_s, cfg_p, cfg_of, cfg_ox, cfg_oy, cfg_ix, cfg_iy, cfg_nif,
               cfg_nif_in_2pow, cfg_ix_in_2pow, cfg_nif_k_k, cfg_mode, res_ready,
        input  dp_reset, dp_en, dp_mode, tile_ox, tile_oy, tile_of, res_valid, busy, done, cfg_err
    );

    modport slave (
        input  start, cfg_k, cfg_s, cfg_p, cfg_of, cfg_ox, cfg_oy, cfg_ix, cfg_iy, cfg_nif,
               cfg_nif_in_2pow, cfg_ix_in_2pow, cfg_nif_k_k, cfg_mode, res_ready,
        output dp_reset, dp_en, dp_mode, tile_ox, tile_oy, tile_of, res_valid, busy, done, cfg_err
    );

endinterface

// File: rtl/conv_tile_iter.sv
// Three-level tile base counter: ox inner, oy middle, of outer.
// last_o flags that the current tile is the final one; an advance on the last tile holds the bases.
module conv_tile_iter
    import conv_cfg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             advance_i,
    input  logic [DIM_W-1:0] lim_ox_i,
    input  logic [DIM_W-1:0] lim_oy_i,
    input  logic [DIM_W-1:0] lim_of_i,
    output logic [DIM_W-1:0] ox_o,
    output logic [DIM_W-1:0] oy_o,
    output logic [DIM_W-1:0] of_o,
    output logic             last_o
);

    localparam logic [DIM_W:0] STEP_X = (DIM_W+1)'(OX_PER_PASS);
    localparam logic [DIM_W:0] STEP_Y = (DIM_W+1)'(OY_PER_PASS);
    localparam logic [DIM_W:0] STEP_F = (DIM_W+1)'(OF_PER_PASS);

    logic [DIM_W-1:0] ox_q, ox_d, oy_q, oy_d, of_q, of_d;
    logic [DIM_W:0]   nx, ny, nf;
    logic             wrap_x, wrap_y, wrap_f;

    // One extra bit so base + step can never wrap back under the limit.
    assign nx     = {1'b0, ox_q} + STEP_X;
    assign ny     = {1'b0, oy_q} + STEP_Y;
    assign nf     = {1'b0, of_q} + STEP_F;
    assign wrap_x = nx >= {1'b0, lim_ox_i};
    assign wrap_y = ny >= {1'b0, lim_oy_i};
    assign wrap_f = nf >= {1'b0, lim_of_i};
    assign last_o = wrap_x & wrap_y & wrap_f;

    always_comb begin
        ox_d = ox_q;
        oy_d = oy_q;
        of_d = of_q;
        if (clear_i) begin
            ox_d = '0;
            oy_d = '0;
            of_d = '0;
        end else if (advance_i && !last_o) begin
            if (!wrap_x) begin
                ox_d = nx[DIM_W-1:0];
            end else begin
                ox_d = '0;
                if (!wrap_y) begin
                    oy_d = ny[DIM_W-1:0];
                end else begin
                    oy_d = '0;
                    of_d = nf[DIM_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ox_q <= '0;
            oy_q <= '0;
            of_q <= '0;
        end else begin
            ox_q <= ox_d;
            oy_q <= oy_d;
            of_q <= of_d;
        end
    end

    assign ox_o = ox_q;
    assign oy_o = oy_q;
    assign of_o = of_q;

endmodule

// File: rtl/conv_tile_scheduler.sv
// Walks a conv layer's output tile space and sequences the datapath one pass per tile.
// state | meaning
// IDLE  | waiting for start; validates and latches the layer config
// PRE   | dp_reset pulse ahead of the pass
// KICK  | dp_en pulse, compute window counter loaded
// RUN   | counting out MAC cycles plus pipeline settle
// HOLD  | res_valid up, waiting for downstream res_ready
// FIN   | done pulse, busy drops on the way back to IDLE
module conv_tile_scheduler
    import conv_cfg_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    conv_tile_scheduler_if.slave  bus
);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    layer_cfg_t       cfg_q, cfg_d;
    logic             accept, advance, err_d, cfg_zero, last;
    logic             dp_reset_q, dp_en_q, res_valid_q, busy_q, done_q, cfg_err_q;
    logic             unused_cfg;

    assign cfg_zero = (bus.cfg_of == '0) || (bus.cfg_ox == '0) || (bus.cfg_oy == '0) ||
                      (bus.cfg_nif == '0) || (bus.cfg_k == '0) || (bus.cfg_nif_k_k == '0);

    // Geometry fields the scheduler itself never needs; they belong to the datapath.
    assign unused_cfg = ^{bus.cfg_s, bus.cfg_p, bus.cfg_ix, bus.cfg_iy,
                          bus.cfg_nif_in_2pow, bus.cfg_ix_in_2pow};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cfg_d   = cfg_q;
        accept  = 1'b0;
        advance = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (cfg_zero) begin
                        err_d = 1'b1;
                    end else begin
                        accept        = 1'b1;
                        cfg_d.of      = bus.cfg_of;
                        cfg_d.ox      = bus.cfg_ox;
                        cfg_d.oy      = bus.cfg_oy;
                        cfg_d.nif_k_k = bus.cfg_nif_k_k;
                        cfg_d.mode    = bus.cfg_mode;
                        state_d       = ST_PRE;
                    end
                end
            end
            ST_PRE:  state_d = ST_KICK;
            ST_KICK: begin
                cnt_d   = CNT_W'(cfg_q.nif_k_k) + CNT_W'(PIPE_LAT - 1);
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_d == '0) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.res_ready) begin
                    advance = 1'b1;
                    state_d = last ? ST_FIN : ST_PRE;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they are glitch-free and clear with reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cfg_q       <= '0;
            dp_reset_q  <= 1'b0;
            dp_en_q     <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cfg_q       <= cfg_d;
            dp_reset_q  <= (state_d == ST_PRE);
            dp_en_q     <= (state_d == ST_KICK);
            res_valid_q <= (state_d == ST_HOLD);
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_FIN);
            cfg_err_q   <= err_d;
        end
    end

    conv_tile_iter u_iter (
        .clk       (clk),
        .rst_n     (reset),
        .clear_i   (accept),
        .advance_i (advance),
        .lim_ox_i  (cfg_q.ox),
        .lim_oy_i  (cfg_q.oy),
        .lim_of_i  (cfg_q.of),
        .ox_o      (bus.tile_ox),
        .oy_o      (bus.tile_oy),
        .of_o      (bus.tile_of),
        .last_o    (last)
    );

    assign bus.dp_reset  = dp_reset_q;
    assign bus.dp_en     = dp_en_q;
    assign bus.dp_mode   = cfg_q.mode;
    assign bus.res_valid = res_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Self-checking bench for conv_tile_scheduler: a tile-list model built from nested loops
// over the layer dims drives expected coordinates, pulse order and compute-window latency.
module tb_conv_tile_scheduler;
    import conv_cfg_pkg::*;

    typedef struct {
        int ox;
        int oy;
        int of;
    } tile_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    conv_tile_scheduler_if bus ();

    conv_tile_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic set_cfg(input int of, input int ox, input int oy, input int nif,
                           input int k, input int nkk, input bit mode);
        bus.cfg_of          = 16'(of);
        bus.cfg_ox          = 16'(ox);
        bus.cfg_oy          = 16'(oy);
        bus.cfg_nif         = 16'(nif);
        bus.cfg_k           = 4'(k);
        bus.cfg_s           = 4'd1;
        bus.cfg_p           = 4'(k / 2);
        bus.cfg_ix          = 16'(ox + k - 1);
        bus.cfg_iy          = 16'(oy + k - 1);
        bus.cfg_nif_in_2pow = 16'($clog2(nif));
        bus.cfg_ix_in_2pow  = 16'($clog2(ox + k - 1));
        bus.cfg_nif_k_k     = 32'(nkk);
        bus.cfg_mode        = mode;
    endtask

    task automatic recover();
        @(negedge clk);
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.res_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Runs one layer against the model tile list. abort_pass >= 0 pulls reset during that pass.
    task automatic run_layer(input int of, input int ox, input int oy, input int nif,
                             input int k, input int nkk, input bit mode,
                             input int dmin, input int dmax, input bit early,
                             input bit poke, input int abort_pass);
        tile_t exp_q[$];
        tile_t t;
        int    cnt, d, lat;
        bit    got, stray;
        for (int f = 0; f < of; f += OF_PER_PASS)
            for (int y = 0; y < oy; y += OY_PER_PASS)
                for (int x = 0; x < ox; x += OX_PER_PASS) begin
                    t.ox = x; t.oy = y; t.of = f;
                    exp_q.push_back(t);
                end
        lat = nkk + PIPE_LAT;
        @(negedge clk);
        set_cfg(of, ox, oy, nif, k, nkk, mode);
        bus.start     = 1'b1;
        bus.res_ready = early;
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.cfg_err !== 1'b0) begin
            n_bad++;
            $display("FAIL accept: busy=%b cfg_err=%b, expected busy=1 cfg_err=0", bus.busy, bus.cfg_err);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            t = exp_q[i];
            n_cmp++;
            if (bus.dp_reset !== 1'b1 || bus.dp_en !== 1'b0 || bus.res_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL pre_pulse pass %0d: dp_reset=%b dp_en=%b res_valid=%b, expected 1 0 0",
                         i, bus.dp_reset, bus.dp_en, bus.res_valid);
            end
            n_cmp++;
            if (bus.tile_ox !== 16'(t.ox) || bus.tile_oy !== 16'(t.oy) || bus.tile_of !== 16'(t.of)) begin
                n_bad++;
                $display("FAIL tile pass %0d: got (%0d,%0d,%0d), expected (%0d,%0d,%0d)", i,
                         bus.tile_ox, bus.tile_oy, bus.tile_of, t.ox, t.oy, t.of);
            end
            n_cmp++;
            if (bus.dp_mode !== mode) begin
                n_bad++;
                $display("FAIL dp_mode pass %0d: got %b, expected %b", i, bus.dp_mode, mode);
            end
            @(negedge clk);
            n_cmp++;
            if (bus.dp_en !== 1'b1 || bus.dp_reset !== 1'b0) begin
                n_bad++;
                $display("FAIL kick_pulse pass %0d: dp_en=%b dp_reset=%b, expected 1 0", i, bus.dp_en, bus.dp_reset);
            end
            cnt = 0; got = 1'b0; stray = 1'b0;
            while (!got && cnt < lat + 8) begin
                @(negedge clk);
                cnt++;
                if (poke && i == 0 && cnt == 2) begin
                    bus.start    = 1'b1;
                    bus.cfg_of   = 16'd999;
                    bus.cfg_ox   = 16'd1;
                    bus.cfg_mode = ~mode;
                end
                if (poke && i == 0 && cnt == 3) begin
                    bus.start = 1'b0;
                    n_cmp++;
                    if (bus.cfg_err !== 1'b0 || bus.busy !== 1'b1) begin
                        n_bad++;
                        $display("FAIL busy_start: cfg_err=%b busy=%b, expected 0 1", bus.cfg_err, bus.busy);
                    end
                end
                if (abort_pass == i && cnt == 4) begin
                    #2 reset = 1'b0;
                    #1;
                    n_cmp++;
                    if ({bus.dp_reset, bus.dp_en, bus.dp_mode, bus.res_valid, bus.busy, bus.done,
                         bus.cfg_err} !== 7'b0 || bus.tile_ox !== 16'd0 || bus.tile_oy !== 16'd0 ||
                        bus.tile_of !== 16'd0) begin
                        n_bad++;
                        $display("FAIL async_reset: outputs dp_reset=%b dp_en=%b busy=%b tile=(%0d,%0d,%0d), expected all 0",
                                 bus.dp_reset, bus.dp_en, bus.busy, bus.tile_ox, bus.tile_oy, bus.tile_of);
                    end
                    repeat (3) @(negedge clk);
                    n_cmp++;
                    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                        n_bad++;
                        $display("FAIL reset_hold: done=%b busy=%b, expected 0 0", bus.done, bus.busy);
                    end
                    reset         = 1'b1;
                    bus.res_ready = 1'b0;
                    @(negedge clk);
                    return;
                end
                if (bus.dp_en === 1'b1 || bus.dp_reset === 1'b1) stray = 1'b1;
                if (bus.res_valid === 1'b1) got = 1'b1;
            end
            n_cmp++;
            if (!got || cnt != lat || stray) begin
                n_bad++;
                $display("FAIL latency pass %0d: res_valid after %0d cycles (seen=%b, stray pulse=%b), expected %0d cycles",
                         i, cnt, got, stray, lat);
            end
            if (!got) begin
                recover();
                return;
            end
            d = early ? 0 : int'($urandom_range(dmax, dmin));
            for (int h = 0; h < d; h++) begin
                @(negedge clk);
                n_cmp++;
                if (bus.res_valid !== 1'b1 || bus.dp_en !== 1'b0 || bus.dp_reset !== 1'b0 ||
                    bus.tile_ox !== 16'(t.ox) || bus.tile_oy !== 16'(t.oy) || bus.tile_of !== 16'(t.of)) begin
                    n_bad++;
                    $display("FAIL hold_stable pass %0d cyc %0d: res_valid=%b dp_en=%b dp_reset=%b tile=(%0d,%0d,%0d)",
                             i, h, bus.res_valid, bus.dp_en, bus.dp_reset, bus.tile_ox, bus.tile_oy, bus.tile_of);
                end
            end
            bus.res_ready = 1'b1;
            @(negedge clk);
            if (!early) bus.res_ready = 1'b0;
        end
        n_cmp++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.res_valid !== 1'b0 || bus.dp_reset !== 1'b0) begin
            n_bad++;
            $display("FAIL fin: done=%b busy=%b res_valid=%b dp_reset=%b, expected 1 1 0 0",
                     bus.done, bus.busy, bus.res_valid, bus.dp_reset);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.dp_mode !== mode) begin
            n_bad++;
            $display("FAIL idle_return: done=%b busy=%b dp_mode=%b, expected 0 0 %b",
                     bus.done, bus.busy, bus.dp_mode, mode);
        end
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        n_cmp++;
        if ({bus.dp_reset, bus.dp_en, bus.dp_mode, bus.res_valid, bus.busy, bus.done, bus.cfg_err} !== 7'b0 ||
            bus.tile_ox !== 16'd0 || bus.tile_oy !== 16'd0 || bus.tile_of !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b dp_reset=%b dp_en=%b res_valid=%b, expected all 0",
                     bus.busy, bus.dp_reset, bus.dp_en, bus.res_valid);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.dp_reset !== 1'b0 || bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: busy=%b dp_reset=%b done=%b, expected 0 0 0",
                     bus.busy, bus.dp_reset, bus.done);
        end
    endtask

    task automatic test_two_pass();
        run_layer(64, 64, 3, 8, 1, 8, 1'b0, 0, 0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_tile_order();
        run_layer(128, 40, 7, 8, 3, 72, 1'b0, 0, 2, 1'b0, 1'b0, -1);
    endtask

    task automatic test_backpressure();
        run_layer(64, 64, 3, 8, 1, 8, 1'b0, 20, 20, 1'b0, 1'b0, -1);
    endtask

    task automatic test_cfg_err();
        for (int z = 0; z < 6; z++) begin
            @(negedge clk);
            set_cfg(z == 0 ? 0 : 64, z == 1 ? 0 : 32, z == 2 ? 0 : 3,
                    z == 3 ? 0 : 8, z == 4 ? 0 : 1, z == 5 ? 0 : 8, 1'b1);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            n_cmp++;
            if (bus.cfg_err !== 1'b1 || bus.busy !== 1'b0) begin
                n_bad++;
                $display("FAIL cfg_err zero field %0d: cfg_err=%b busy=%b, expected 1 0", z, bus.cfg_err, bus.busy);
            end
            @(negedge clk);
            n_cmp++;
            if (bus.cfg_err !== 1'b0 || bus.busy !== 1'b0 || bus.dp_reset !== 1'b0 || bus.dp_mode !== 1'b0) begin
                n_bad++;
                $display("FAIL cfg_err_pulse field %0d: cfg_err=%b busy=%b dp_reset=%b dp_mode=%b, expected 0 0 0 0",
                         z, bus.cfg_err, bus.busy, bus.dp_reset, bus.dp_mode);
            end
        end
    endtask

    task automatic test_busy_start();
        run_layer(64, 40, 4, 4, 1, 4, 1'b0, 0, 1, 1'b0, 1'b1, -1);
    endtask

    task automatic test_reset_midrun();
        run_layer(128, 40, 7, 8, 3, 72, 1'b0, 0, 0, 1'b0, 1'b0, 2);
        run_layer(128, 40, 7, 8, 3, 72, 1'b0, 0, 1, 1'b0, 1'b0, -1);
    endtask

    task automatic test_mode();
        run_layer(64, 64, 6, 2, 1, 2, 1'b1, 0, 0, 1'b1, 1'b0, -1);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (bus.dp_mode !== 1'b1) begin
            n_bad++;
            $display("FAIL mode_idle_hold: dp_mode=%b, expected 1", bus.dp_mode);
        end
        run_layer(32, 20, 2, 1, 1, 1, 1'b0, 0, 1, 1'b0, 1'b0, -1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            run_layer(int'($urandom_range(200, 1)), int'($urandom_range(100, 1)), int'($urandom_range(9, 1)),
                      int'($urandom_range(8, 1)), int'($urandom_range(3, 1)), int'($urandom_range(20, 1)),
                      1'($urandom_range(1, 0)), 0, 3, 1'($urandom_range(1, 0)), 1'b0, -1);
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.res_ready = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 1'b0);
        test_reset();
        test_two_pass();
        test_tile_order();
        test_backpressure();
        test_cfg_err();
        test_busy_start();
        test_reset_midrun();
        test_mode();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
